// File: rtl/mem_scan_reader.sv
// mem_scan_reader
//   Read-back engine for the datapath dual-port memory. On start it reads
//   every address from 0 to 2^ADDR_W-1, one read at a time. Each word is
//   offered on a valid/ready stream. Each word is also checked against the
//   data == address invariant, because the write side stores every result s
//   at address s. Mismatches are counted, and the first failing address is
//   latched.
//
// Ports
//   clk            memory clock (40 MHz domain)
//   rst            synchronous reset, active low
//   start          begin a sweep (only honoured in IDLE)
//   busy           sweep in progress (READ/WAIT/PRESENT)
//   done           one-cycle pulse after the last word transfers
//   rden           memory read enable
//   rdaddress      memory read address
//   q              memory read data, valid READ_LAT cycles after rden
//   out_data       captured word
//   out_addr       address of out_data
//   out_valid      stream valid
//   out_ready      stream ready
//   err_count      mismatching words in the current/last sweep
//   first_err_addr address of the first mismatch
//   err_flag       err_count != 0
module mem_scan_reader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rden,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag
);

  localparam int CMP_W = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, PRESENT, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  // vld_pipe[0] marks the READ cycle, vld_pipe[k] the k-th WAIT cycle, so
  // vld_pipe[READ_LAT] flags the cycle whose closing edge samples q.
  logic [READ_LAT:0] vld_pipe;
  logic              last_wait;
  logic              xfer;
  logic              mismatch;

  assign last_wait = (state == WAIT) && vld_pipe[READ_LAT];
  assign xfer      = (state == PRESENT) && out_ready;
  assign mismatch  = q[CMP_W-1:0] != addr_cnt[CMP_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    if (vld_pipe[READ_LAT]) state_nxt = PRESENT;
      PRESENT: if (out_ready) state_nxt = (addr_cnt == TOP_ADDR) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe       <= '0;
      addr_cnt       <= '0;
      out_data       <= '0;
      out_addr       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[READ_LAT-1:0], state_nxt == READ};
      if (state == IDLE && start) begin
        addr_cnt       <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
      end
      if (last_wait) begin
        out_data <= q;
        out_addr <= addr_cnt;
        if (mismatch) begin
          err_count <= err_count + (ADDR_W+1)'(1);
          if (err_count == '0) first_err_addr <= addr_cnt;
        end
      end
      // Termination is decided before increment, so the counter never wraps.
      if (xfer && addr_cnt != TOP_ADDR) addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  assign rden      = (state == READ);
  assign rdaddress = addr_cnt;
  assign busy      = (state == READ) || (state == WAIT) || (state == PRESENT);
  assign done      = (state == DONE);
  assign out_valid = (state == PRESENT);
  assign err_flag  = (err_count != '0);

endmodule

// File: doc/mem_scan_reader.md
# mem_scan_reader

Sequential read-back engine for the 8-bit dual-port memory in the 40 MHz datapath. The datapath write side stores each registered adder result `s` at address `s`, so every populated location holds its own address. On `start`, this block sweeps the read port from address 0 to the top address, one read at a time. It presents each word on a valid/ready output stream and checks it against the data == address invariant, keeping mismatch statistics. It sits on the `rden`/`rdaddress`/`q` side of the memory, clocked by the same 40 MHz PLL output.

## Interface
- `ADDR_W`, 8, memory address width; sweep covers 0 .. 2^ADDR_W-1
- `DATA_W`, 8, memory data width; compare uses the low `min(ADDR_W,DATA_W)` bits
- `READ_LAT`, 1, memory read latency in cycles from `rden` to valid `q` (legal 1..3)
- `clk`  in  1  memory clock (40 MHz domain)
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a sweep; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until the last word transfers
- `done`  out  1  one-cycle pulse after the last word transfers
- `rden`  out  1  memory read enable
- `rdaddress`  out  ADDR_W  memory read address
- `q`  in  DATA_W  memory read data
- `out_data`  out  DATA_W  captured word
- `out_addr`  out  ADDR_W  address of `out_data`
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready
- `err_count`  out  ADDR_W+1  number of mismatching words in the current or last sweep
- `first_err_addr`  out  ADDR_W  address of the first mismatch
- `err_flag`  out  1  `err_count != 0`

## Operation
- Reset (`rst`=0 at a rising edge): state IDLE. All outputs are 0, including `rdaddress`, `out_*` and the error registers.
- FSM states: IDLE, READ, WAIT, PRESENT, DONE.
- IDLE:
  - `start`=1 moves to READ.
  - On that edge: address counter := 0, `err_count` := 0, `first_err_addr` := 0.
- READ, exactly 1 cycle:
  - `rden`=1 and `rdaddress`=counter; go to WAIT.
  - `rden` is 0 in every other state.
- WAIT, exactly READ_LAT cycles:
  - `rdaddress` is held.
  - On the last WAIT edge, capture `out_data`:=`q` and `out_addr`:=counter.
  - Compare `q` to counter. On mismatch, increment `err_count`; if it was 0, also latch `first_err_addr`:=counter.
  - Go to PRESENT.
- PRESENT:
  - `out_valid`=1; `out_data` and `out_addr` are stable while `out_ready`=0.
  - On `out_ready`=1: if counter = top address, go to DONE; otherwise increment the counter and go to READ.
- DONE: `done`=1 for one cycle, then IDLE.
  - `err_count`, `first_err_addr` and `out_data` hold their values until the next accepted `start`.
  - `out_valid` is 0.
- `busy`=1 in READ, WAIT and PRESENT only.
- `start` outside IDLE is ignored and has no side effects.
- The address counter never wraps within a sweep; termination is detected before increment.
- `err_count` width ADDR_W+1 holds the maximum 2^ADDR_W, so no saturation is needed.
- Reset mid-sweep overrides everything: next cycle is IDLE with all outputs 0 and no further `rden`.

## Timing
- `start` accepted at edge E0.
- With READ_LAT=1:
  - READ in cycle 1 (`rden`=1, address 0), WAIT in cycle 2, PRESENT in cycle 3.
- Per word: 2 + READ_LAT cycles plus any cycles with `out_valid`=1 and `out_ready`=0.
- Full sweep with `out_ready` held at 1, ADDR_W=8, READ_LAT=1: words occupy cycles 1..768, `done` is high in cycle 769, IDLE in cycle 770.
- `q` is sampled exactly READ_LAT edges after the edge that ends the READ cycle.
- At most one read is outstanding; there is no pipelining of reads.
- A stream transfer occurs on an edge where `out_valid`=1 and `out_ready`=1.
- `out_ready` has no combinational path to any output.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 for 3 cycles with random `start`/`out_ready`.
  - Response: all outputs 0; `rden` never asserted.
- Clean sweep:
  - Stimulus: memory model with READ_LAT=1 prefilled data=addr; `start` pulse; `out_ready`=1.
  - Response: 256 transfers with `out_addr`=`out_data`=0..255 in order; `err_count`=0; `err_flag`=0; `done` in cycle 769.
- Corrupt sweep:
  - Stimulus: prefill as above but address 0x10 := 0x00 and address 0x80 := 0xFF.
  - Response: `err_count`=2; `first_err_addr`=0x10; `err_flag`=1; `out_data`=0x00 at `out_addr`=0x10.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles while word 3 is presented.
  - Response: `out_data`=3 and `out_addr`=3 stable for 6 cycles; no `rden` during the stall; the next read is address 4.
- Start/reset interference:
  - Stimulus: `start` pulses during a sweep; later `rst`=0 for one cycle while word 50 is in WAIT.
  - Response: the `start` pulses are ignored. The cycle after reset, all outputs are 0 and the FSM is IDLE. A new `start` restarts the sweep at address 0 with the error registers cleared.
- Latency parameter:
  - Stimulus: READ_LAT=3 with a 3-cycle memory model.
  - Response: 5 cycles per word; correct data capture; `done` in cycle 1281.
